control_unit_seq: RTL and testbench

CONTROL_UNIT_SEQ -- requirements
Module: control_unit_seq

---
 rtl/control_unit_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_control_unit_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/control_unit_seq.sv
// rtl/control_unit_seq.sv - RV32IM decode with registered E-stage controls and multi-cycle M-op occupancy FSM
module control_unit_seq #(
  parameter int M_EXT      = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           InstrD,
  input  logic                  ValidD,
  input  logic                  StallE,
  input  logic                  FlushE,
  output logic [2:0]            ImmSrcD,
  output logic                  StallD,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  MemReadE,
  output logic                  JumpE,
  output logic                  JumpTypeE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [2:0]            ResultSrcE,
  output logic [2:0]            BranchTypeE,
  output logic [2:0]            StrobeE,
  output logic [1:0]            SLTControlE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  MulDivBusyE,
  output logic                  IllegalE
);

  localparam logic [6:0] OP_RTYPE = 7'b0110011, OP_ITYPE = 7'b0010011, OP_LOAD  = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_JAL   = 7'b1101111, OP_JALR  = 7'b1100111,
                         OP_BRANCH = 7'b1100011, OP_LUI  = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  typedef enum logic {IDLE, MULDIV} state_t;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic                  jump;
    logic                  jump_type;
    logic                  branch;
    logic                  alu_src;
    logic [2:0]            result_src;
    logic [2:0]            branch_type;
    logic [2:0]            strobe;
    logic [1:0]            slt;
    logic [ALU_CTRL_W-1:0] alu;
    logic                  illegal;
  } ectl_t;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       is_m_op;
  logic       m_start;
  int         m_cycles;
  logic       unused_bits;
  ectl_t      dec, e_q;
  state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  assign op          = InstrD[6:0];
  assign f3          = InstrD[14:12];
  assign f7          = InstrD[31:25];
  assign unused_bits = ^{InstrD[24:15], InstrD[11:7]};
  assign is_m_op     = (op == OP_RTYPE) && (f7 == 7'b0000001);
  assign m_cycles    = f3[2] ? DIV_CYCLES : MUL_CYCLES;
  assign m_start     = ValidD && is_m_op && (M_EXT != 0) && (m_cycles > 1);

  // alt selects SUB/SRA; SLT-class always subtracts so the ALU flags drive the compare
  function automatic logic [3:0] alu_base(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  alu_base = alt ? 4'd1 : 4'd0;
      3'b001:  alu_base = 4'd5;
      3'b010,
      3'b011:  alu_base = 4'd1;
      3'b100:  alu_base = 4'd4;
      3'b101:  alu_base = alt ? 4'd6 : 4'd7;
      3'b110:  alu_base = 4'd3;
      default: alu_base = 4'd2;
    endcase
  endfunction

  always_comb begin
    dec     = '0;
    ImmSrcD = 3'd0;
    case (op)
      OP_RTYPE: begin
        if (is_m_op) begin
          if (M_EXT != 0) begin
            dec.reg_write = 1'b1;
            dec.alu       = ALU_CTRL_W'({1'b1, f3});
          end else begin
            dec.illegal = 1'b1;
          end
        end else begin
          dec.reg_write = 1'b1;
          dec.alu       = ALU_CTRL_W'(alu_base(f3, f7[5]));
          dec.slt       = (f3 == 3'b010) ? 2'd1 : (f3 == 3'b011) ? 2'd2 : 2'd0;
        end
      end
      OP_ITYPE: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu       = ALU_CTRL_W'(alu_base(f3, (f3 == 3'b101) && f7[5]));
        dec.slt       = (f3 == 3'b010) ? 2'd1 : (f3 == 3'b011) ? 2'd2 : 2'd0;
        ImmSrcD       = (f3 == 3'b001 || f3 == 3'b101) ? 3'd5 : 3'd0;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 3'd1;
        dec.strobe     = f3;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.strobe    = f3;
        ImmSrcD       = 3'd1;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 3'd2;
        ImmSrcD        = 3'd3;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.jump_type  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 3'd2;
      end
      OP_BRANCH: begin
        dec.branch      = 1'b1;
        dec.branch_type = f3;
        dec.alu         = ALU_CTRL_W'(4'd1);
        dec.slt         = f3[2] ? (f3[1] ? 2'd2 : 2'd1) : 2'd0;
        ImmSrcD         = 3'd2;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 3'd3;
        ImmSrcD        = 3'd4;
      end
      OP_AUIPC: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 3'd4;
        ImmSrcD        = 3'd4;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // The counter runs even under StallE, so occupancy is a fixed N cycles
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (FlushE) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: if (!StallE && m_start) begin
          state_n = MULDIV;
          cnt_n   = CNT_W'(m_cycles - 1);
        end
        MULDIV: begin
          if (cnt == CNT_W'(1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    StallD      = (state == MULDIV);
    MulDivBusyE = (state == MULDIV);
  end

  always_ff @(posedge CLK) begin
    if (!RST)                    e_q <= '0;
    else if (FlushE)             e_q <= '0;
    else if (!(StallE || StallD)) e_q <= ValidD ? dec : '0;
  end

  assign RegWriteE   = e_q.reg_write;
  assign MemWriteE   = e_q.mem_write;
  assign MemReadE    = e_q.mem_read;
  assign JumpE       = e_q.jump;
  assign JumpTypeE   = e_q.jump_type;
  assign BranchE     = e_q.branch;
  assign ALUSrcE     = e_q.alu_src;
  assign ResultSrcE  = e_q.result_src;
  assign BranchTypeE = e_q.branch_type;
  assign StrobeE     = e_q.strobe;
  assign SLTControlE = e_q.slt;
  assign ALUControlE = e_q.alu;
  assign IllegalE    = e_q.illegal;

endmodule

// File: tb/tb_control_unit_seq.sv
// tb/tb_control_unit_seq.sv - directed checks of control_unit_seq across three parameter sets
module tb_control_unit_seq;

  localparam logic [31:0] I_ADD  = 32'h002081B3, I_DIV  = 32'h0220C1B3, I_MUL  = 32'h022081B3,
                          I_BEQ  = 32'h00208063, I_BAD  = 32'h0000007F, I_LW   = 32'h0000A183,
                          I_SW   = 32'h0020A023, I_SLLI = 32'h00109193, I_JAL  = 32'h000000EF,
                          I_LUI  = 32'h000000B7, I_SLTU = 32'h0020B1B3;

  logic CLK, RST, ValidD, StallE, FlushE;
  logic [31:0] InstrD;
  int n_checks = 0, n_errors = 0;

  // a_: defaults, b_: MUL_CYCLES=1, c_: M_EXT=0
  logic [2:0] a_imm, b_imm, c_imm;
  logic a_stalld, a_rw, a_mw, a_mr, a_j, a_jt, a_br, a_as, a_busy, a_ill;
  logic b_stalld, b_rw, b_mw, b_mr, b_j, b_jt, b_br, b_as, b_busy, b_ill;
  logic c_stalld, c_rw, c_mw, c_mr, c_j, c_jt, c_br, c_as, c_busy, c_ill;
  logic [2:0] a_rs, a_bt, a_st, b_rs, b_bt, b_st, c_rs, c_bt, c_st;
  logic [1:0] a_slt, b_slt, c_slt;
  logic [3:0] a_alu, b_alu, c_alu;
  logic [24:0] a_all;

  assign a_all = {a_rw, a_mw, a_mr, a_j, a_jt, a_br, a_as, a_rs, a_bt, a_st, a_slt, a_alu, a_busy, a_ill, a_stalld};

  control_unit_seq u_a (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .ImmSrcD(a_imm), .StallD(a_stalld), .RegWriteE(a_rw), .MemWriteE(a_mw), .MemReadE(a_mr),
    .JumpE(a_j), .JumpTypeE(a_jt), .BranchE(a_br), .ALUSrcE(a_as), .ResultSrcE(a_rs),
    .BranchTypeE(a_bt), .StrobeE(a_st), .SLTControlE(a_slt), .ALUControlE(a_alu),
    .MulDivBusyE(a_busy), .IllegalE(a_ill));

  control_unit_seq #(.MUL_CYCLES(1)) u_b (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .ImmSrcD(b_imm), .StallD(b_stalld), .RegWriteE(b_rw), .MemWriteE(b_mw), .MemReadE(b_mr),
    .JumpE(b_j), .JumpTypeE(b_jt), .BranchE(b_br), .ALUSrcE(b_as), .ResultSrcE(b_rs),
    .BranchTypeE(b_bt), .StrobeE(b_st), .SLTControlE(b_slt), .ALUControlE(b_alu),
    .MulDivBusyE(b_busy), .IllegalE(b_ill));

  control_unit_seq #(.M_EXT(0)) u_c (
    .CLK(CLK), .RST(RST), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .ImmSrcD(c_imm), .StallD(c_stalld), .RegWriteE(c_rw), .MemWriteE(c_mw), .MemReadE(c_mr),
    .JumpE(c_j), .JumpTypeE(c_jt), .BranchE(c_br), .ALUSrcE(c_as), .ResultSrcE(c_rs),
    .BranchTypeE(c_bt), .StrobeE(c_st), .SLTControlE(c_slt), .ALUControlE(c_alu),
    .MulDivBusyE(c_busy), .IllegalE(c_ill));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b0; ValidD = 1'b0; StallE = 1'b0; FlushE = 1'b0; InstrD = I_ADD;
    tick(); tick();
    check("reset_all", a_all, 0);

    RST = 1'b1; ValidD = 1'b1; InstrD = I_ADD;
    tick();
    check("add_rw", a_rw, 1);
    check("add_alu", a_alu, 0);
    check("add_alusrc", a_as, 0);
    check("add_rsrc", a_rs, 0);
    check("add_ill", a_ill, 0);

    ValidD = 1'b0;
    tick();
    check("bubble_all", a_all, 0);

    ValidD = 1'b1; InstrD = I_LW;
    #1 check("lw_imm", a_imm, 0);
    tick();
    check("lw_ctl", {a_mr, a_mw, a_rw, a_as, a_rs, a_st}, {1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 3'd2});

    InstrD = I_SW;
    #1 check("sw_imm", a_imm, 1);
    tick();
    check("sw_ctl", {a_mr, a_mw, a_rw, a_as, a_st}, {1'b0, 1'b1, 1'b0, 1'b1, 3'd2});

    InstrD = I_SLTU;
    tick();
    check("sltu_ctl", {a_alu, a_slt, a_rw}, {4'd1, 2'd2, 1'b1});

    InstrD = I_SLLI;
    #1 check("slli_imm", a_imm, 5);
    tick();
    check("slli_alu", {a_alu, a_as}, {4'd5, 1'b1});

    InstrD = I_JAL;
    #1 check("jal_imm", a_imm, 3);
    tick();
    check("jal_ctl", {a_j, a_jt, a_rs, a_rw}, {1'b1, 1'b0, 3'd2, 1'b1});

    InstrD = I_LUI;
    #1 check("lui_imm", a_imm, 4);
    tick();
    check("lui_rsrc", a_rs, 3);

    // full-length DIV: 32 busy cycles, result held, next instruction on the 34th
    InstrD = I_DIV;
    tick();
    InstrD = I_ADD;
    check("div_busy_1", {a_busy, a_stalld, a_alu}, {1'b1, 1'b1, 4'd12});
    for (int i = 2; i <= 32; i++) begin
      tick();
      check($sformatf("div_busy_%0d", i), {a_busy, a_stalld, a_alu}, {1'b1, 1'b1, 4'd12});
    end
    tick();
    check("div_33", {a_busy, a_stalld, a_alu, a_rw}, {1'b0, 1'b0, 4'd12, 1'b1});
    tick();
    check("div_34_next", {a_busy, a_alu, a_rw}, {1'b0, 4'd0, 1'b1});

    // MUL on each parameter set
    InstrD = I_MUL;
    tick();
    InstrD = I_ADD;
    check("mul2_busy", {a_busy, a_alu}, {1'b1, 4'd8});
    check("mul1_nostall", {b_busy, b_stalld, b_alu, b_rw}, {1'b0, 1'b0, 4'd8, 1'b1});
    check("nom_mul_ill", {c_ill, c_rw, c_mw, c_mr, c_j, c_br}, {1'b1, 5'd0});
    tick();
    check("mul2_hold", {a_busy, a_alu}, {1'b0, 4'd8});
    check("mul1_next", {b_stalld, b_alu, b_rw}, {1'b0, 4'd0, 1'b1});
    tick();
    check("mul2_next", a_alu, 0);

    InstrD = I_BAD;
    tick();
    check("bad_op", {a_ill, a_rw, a_mw, a_mr, a_j, a_br}, {1'b1, 5'd0});

    // FlushE on cycle 5 of a DIV
    InstrD = I_DIV;
    tick();
    InstrD = I_ADD;
    for (int i = 2; i <= 4; i++) tick();
    check("flush_pre", a_busy, 1);
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    check("flush_all", a_all, 0);
    tick();
    check("flush_idle", {a_rw, a_alu, a_stalld}, {1'b1, 4'd0, 1'b0});

    // StallE hold
    StallE = 1'b1; InstrD = I_LW;
    tick();
    check("stalle_hold", {a_rw, a_mr}, {1'b1, 1'b0});
    StallE = 1'b0;

    // reset mid-DIV with StallE asserted
    InstrD = I_DIV;
    tick();
    InstrD = I_ADD;
    tick(); tick();
    StallE = 1'b1; RST = 1'b0;
    tick();
    check("rst_mid_div", a_all, 0);
    RST = 1'b1; StallE = 1'b0; InstrD = I_BEQ;
    #1 check("beq_imm", a_imm, 2);
    tick();
    check("beq_ctl", {a_br, a_bt, a_alu, a_rw, a_busy}, {1'b1, 3'd0, 4'd1, 1'b0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
